// File: rtl/cpu_fetch_stream.sv
// Instruction fetch unit: Wishbone-classic word reads into a halfword circular
// prefetch buffer, presenting opcode + operand window to decode.
module cpu_fetch_stream #(
    parameter logic [31:0] BOOT_ADDR = 32'h00001000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        consume_i,
    input  logic        consume_len_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic        operand_valid_o,
    output logic [31:0] pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    state_t            r_state;
    logic [31:0]       r_fetch_addr;
    logic              r_drop_first;
    logic [31:0]       r_adr;
    logic              r_cyc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [15:0]       r_buf [DEPTH];
    logic [31:0]       r_pc;

    logic              w_valid;
    logic              w_operand_valid;
    logic              w_has_space;
    logic              w_ack_take;
    logic              w_consume_ok;
    logic [1:0]        w_n_written;
    logic [1:0]        w_n_consumed;

    assign w_valid         = (r_count != '0);
    assign w_operand_valid = (r_count >= CNT_W'(3));
    assign w_has_space     = (r_count <= CNT_W'(DEPTH - 2));

    // Only a normal REQ ack lands in the buffer; DISCARD acks and acks that
    // coincide with a redirect belong to the abandoned stream.
    assign w_ack_take   = (r_state == S_REQ) && wb_ack_i && !redirect_i;
    assign w_n_written  = w_ack_take ? (r_drop_first ? 2'd1 : 2'd2) : 2'd0;
    assign w_consume_ok = consume_i && !redirect_i &&
                          (consume_len_i ? w_operand_valid : w_valid);
    assign w_n_consumed = w_consume_ok ? (consume_len_i ? 2'd3 : 2'd1) : 2'd0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_cyc        <= 1'b0;
            r_adr        <= '0;
            r_fetch_addr <= BOOT_ADDR & ~32'h3;
            r_drop_first <= BOOT_ADDR[1];
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!redirect_i && w_has_space) begin
                        r_state <= S_REQ;
                        r_cyc   <= 1'b1;
                        r_adr   <= r_fetch_addr;
                    end
                end
                S_REQ: begin
                    if (wb_ack_i) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                    end else if (redirect_i) begin
                        r_state <= S_DISCARD;
                    end
                    if (w_ack_take) begin
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        r_drop_first <= 1'b0;
                    end
                end
                S_DISCARD: begin
                    if (wb_ack_i) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
            // The bus cycle in flight keeps its address; only the next fetch moves.
            if (redirect_i) begin
                r_fetch_addr <= redirect_pc_i & ~32'h3;
                r_drop_first <= redirect_pc_i[1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_pc     <= BOOT_ADDR & ~32'h1;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (redirect_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_pc     <= redirect_pc_i & ~32'h1;
        end else begin
            if (w_ack_take) begin
                if (r_drop_first) begin
                    r_buf[r_wr_ptr] <= wb_dat_i[15:0];
                end else begin
                    r_buf[r_wr_ptr]               <= wb_dat_i[31:16];
                    r_buf[r_wr_ptr + PTR_W'(1)]   <= wb_dat_i[15:0];
                end
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_written);
            end
            if (w_consume_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_consumed);
                r_pc     <= r_pc + (consume_len_i ? 32'd6 : 32'd2);
            end
            r_count <= r_count + CNT_W'(w_n_written) - CNT_W'(w_n_consumed);
        end
    end

    assign wb_adr_o        = r_adr;
    assign wb_cyc_o        = r_cyc;
    assign wb_stb_o        = r_cyc;
    assign opcode_o        = r_buf[r_rd_ptr];
    assign operand_o       = {r_buf[r_rd_ptr + PTR_W'(1)], r_buf[r_rd_ptr + PTR_W'(2)]};
    assign valid_o         = w_valid;
    assign operand_valid_o = w_operand_valid;
    assign pc_o            = r_pc;

endmodule

// File: tb/tb_cpu_fetch_stream.sv
// Scoreboard bench for cpu_fetch_stream: a Wishbone memory model with
// adjustable stalls feeds the DUT; consumed instructions are checked in order.
module tb_cpu_fetch_stream;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        consume_i = 1'b0;
    logic        consume_len_i = 1'b0;
    logic [15:0] opcode_o;
    logic [31:0] operand_o;
    logic        valid_o;
    logic        operand_valid_o;
    logic [31:0] pc_o;

    cpu_fetch_stream #(.BOOT_ADDR(32'h00001000), .DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .consume_i(consume_i), .consume_len_i(consume_len_i),
        .opcode_o(opcode_o), .operand_o(operand_o),
        .valid_o(valid_o), .operand_valid_o(operand_valid_o), .pc_o(pc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00001000: return 32'h12345678;
            32'h00001004: return 32'h9ABCDEF0;
            default:      return {a[15:0] ^ 16'hC3C3, a[15:0] ^ 16'h3C3C};
        endcase
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[15:0] : w[31:16];
    endfunction

    // Memory model: registered ack, optional stall on one address, and an
    // ack budget that lets the bench freeze the bus.
    logic [31:0] acked[$];
    int          ack_limit = 1000000;
    logic [31:0] wait_adr  = 32'hFFFFFFFF;
    int          wait_n    = 0;
    int          wcnt      = 0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_ack_i <= 1'b0;
            wcnt     <= 0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (wcnt >= ((wb_adr_o == wait_adr) ? wait_n : 0) && acked.size() < ack_limit) begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= mem_word(wb_adr_o);
                wcnt     <= 0;
                acked.push_back(wb_adr_o);
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [15:0] op;
        logic [31:0] opnd;
        logic        len;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc = 32'h00001000;

    task automatic do_consume(input logic len);
        exp_t e;
        int   k;
        e.pc   = m_pc;
        e.op   = hw(m_pc);
        e.opnd = {hw(m_pc + 32'd2), hw(m_pc + 32'd4)};
        e.len  = len;
        sb.push_back(e);
        for (k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (len ? operand_valid_o : valid_o) break;
        end
        if (k == 60) chk("consume_wait_timeout", 32'd0, 32'd1);
        e = sb.pop_front();
        chk("sb_pc", pc_o, e.pc);
        chk("sb_opcode", {16'h0, opcode_o}, {16'h0, e.op});
        if (e.len) chk("sb_operand", operand_o, e.opnd);
        consume_i     = 1'b1;
        consume_len_i = len;
        @(negedge clk_i);
        consume_i     = 1'b0;
        m_pc          = m_pc + (len ? 32'd6 : 32'd2);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        consume_i  = 1'b0;
        acked.delete();
        sb.delete();
        m_pc = 32'h00001000;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int k;

        // Reset state and first-opcode latency with only two words available
        ack_limit = 2;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_cyc", {31'h0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'h0, wb_stb_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_valid", {30'h0, valid_o, operand_valid_o}, 32'd0);
        chk("rst_opcode", {16'h0, opcode_o}, 32'd0);
        chk("rst_operand", operand_o, 32'd0);
        chk("rst_pc", pc_o, 32'h00001000);
        rst_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (i == 1) begin
                chk("first_req_cyc", {31'h0, wb_cyc_o}, 32'd1);
                chk("first_req_adr", wb_adr_o, 32'h00001000);
            end
            if (valid_o) begin
                lat = i;
                break;
            end
        end
        chk("first_opcode_latency", lat, 32'd3);
        for (k = 0; k < 20; k++) begin
            if (operand_valid_o) break;
            @(negedge clk_i);
        end
        chk("boot_opcode", {16'h0, opcode_o}, 32'h00001234);
        chk("boot_operand", operand_o, 32'h56789ABC);
        chk("boot_pc", pc_o, 32'h00001000);
        chk("boot_valids", {30'h0, valid_o, operand_valid_o}, 32'd3);
        do_consume(1'b1);
        do_consume(1'b0);
        chk("drained_valid", {31'h0, valid_o}, 32'd0);
        chk("drained_pc", pc_o, 32'h00001008);
        chk("drained_req_adr", wb_adr_o, 32'h00001008);
        ack_limit = 1000000;
        do_consume(1'b0);

        // No consumption: buffer fills with exactly four words, then holds
        do_reset();
        repeat (60) @(negedge clk_i);
        chk("full_req_count", acked.size(), 32'd4);
        if (acked.size() == 4) chk("full_last_adr", acked[3], 32'h0000100C);
        chk("full_cyc_idle", {31'h0, wb_cyc_o}, 32'd0);
        do_consume(1'b0);
        repeat (10) @(negedge clk_i);
        chk("one_free_no_req", acked.size(), 32'd4);
        chk("one_free_cyc", {31'h0, wb_cyc_o}, 32'd0);
        do_consume(1'b0);
        for (k = 0; k < 10; k++) begin
            if (wb_cyc_o) break;
            @(negedge clk_i);
        end
        chk("two_free_req_adr", wb_adr_o, 32'h00001010);

        // Redirect while a stalled request is outstanding
        do_reset();
        wait_adr = 32'h00001008;
        wait_n   = 3;
        for (k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o && wb_adr_o == 32'h00001008) break;
        end
        if (k == 40) chk("stall_req_timeout", 32'd0, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h00002002;
        @(negedge clk_i);
        redirect_i = 1'b0;
        m_pc       = 32'h00002002;
        sb.delete();
        chk("redir_valid", {31'h0, valid_o}, 32'd0);
        chk("redir_pc", pc_o, 32'h00002002);
        chk("discard_hold_cyc", {31'h0, wb_cyc_o}, 32'd1);
        chk("discard_hold_adr", wb_adr_o, 32'h00001008);
        @(negedge clk_i);
        chk("discard_hold_cyc2", {31'h0, wb_cyc_o}, 32'd1);
        for (k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o && wb_adr_o != 32'h00001008) break;
        end
        chk("redir_req_adr", wb_adr_o, 32'h00002000);
        wait_adr = 32'hFFFFFFFF;
        do_consume(1'b0);
        do_consume(1'b1);

        // Redirect coinciding with an ack and a consume
        for (k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (wb_ack_i && valid_o) break;
        end
        if (k == 40) chk("coinc_ack_timeout", 32'd0, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h00003004;
        consume_i     = 1'b1;
        consume_len_i = 1'b0;
        @(negedge clk_i);
        redirect_i = 1'b0;
        consume_i  = 1'b0;
        m_pc       = 32'h00003004;
        chk("coinc_valids", {30'h0, valid_o, operand_valid_o}, 32'd0);
        chk("coinc_pc", pc_o, 32'h00003004);
        for (k = 0; k < 10; k++) begin
            if (wb_cyc_o) break;
            @(negedge clk_i);
        end
        chk("coinc_req_adr", wb_adr_o, 32'h00003004);
        do_consume(1'b0);
        do_consume(1'b1);

        // Asynchronous reset in the middle of a bus cycle
        ack_limit = acked.size();
        for (k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) break;
        end
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("async_rst_valid", {31'h0, valid_o}, 32'd0);
        chk("async_rst_pc", pc_o, 32'h00001000);
        @(negedge clk_i);
        acked.delete();
        sb.delete();
        ack_limit = 1000000;
        m_pc      = 32'h00001000;
        @(negedge clk_i);
        rst_i = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) break;
        end
        chk("restart_req_adr", wb_adr_o, 32'h00001000);
        do_consume(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
